// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM: gathers little-endian bytes into
// DATA_WIDTH-bit words and writes them to sequential addresses from 0.
module imem_loader #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int BYTES    = (DATA_WIDTH + 7) / 8;
  localparam int LOW_W    = 8 * (BYTES - 1);
  localparam int TOP_BITS = DATA_WIDTH - LOW_W;
  localparam int IDX_W    = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam int CNT_W    = ADDRESS_WIDTH + 1;

  localparam logic [CNT_W-1:0]         MEM_SIZE_C = CNT_W'(MEM_SIZE);
  localparam logic [CNT_W-1:0]         ZERO_CNT   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]         ONE_CNT    = CNT_W'(1);
  localparam logic [IDX_W-1:0]         ZERO_IDX   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]         ONE_IDX    = IDX_W'(1);
  localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR  = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] ONE_ADDR   = ADDRESS_WIDTH'(1);
  // Bits of the final byte that lie beyond DATA_WIDTH must be zero.
  localparam logic [7:0]               PAD_MASK   = 8'hFF << TOP_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                   state_r;
  logic [IDX_W-1:0]         byte_idx_r;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [CNT_W-1:0]         remaining_r;
  logic [LOW_W-1:0]         word_r;
  logic [CNT_W-1:0]         count_clamped_s;

  logic                     byte_ready_r;
  logic                     mem_we_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0]    mem_wdata_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     error_r;

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

  // Clamp the requested word count to the RAM depth.
  always_comb begin
    count_clamped_s = word_count;
    if (word_count > MEM_SIZE_C) begin
      count_clamped_s = MEM_SIZE_C;
    end else begin
      count_clamped_s = word_count;
    end
  end

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      byte_idx_r   <= ZERO_IDX;
      addr_r       <= ZERO_ADDR;
      remaining_r  <= ZERO_CNT;
      word_r       <= {LOW_W{1'b0}};
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= ZERO_ADDR;
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            error_r     <= 1'b0;
            addr_r      <= ZERO_ADDR;
            byte_idx_r  <= ZERO_IDX;
            remaining_r <= count_clamped_s;
            busy_r      <= 1'b1;
            if (count_clamped_s == ZERO_CNT) begin
              state_r <= FINISH;
              done_r  <= 1'b1;
            end else begin
              state_r      <= RECV;
              byte_ready_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RECV: begin
          if (byte_valid) begin
            if (byte_idx_r == LAST_IDX) begin
              byte_ready_r <= 1'b0;
              if ((byte_data & PAD_MASK) != 8'h00) begin
                error_r <= 1'b1;
                done_r  <= 1'b1;
                state_r <= FINISH;
              end else begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= addr_r;
                mem_wdata_r <= {byte_data[TOP_BITS-1:0], word_r};
                state_r     <= WRITE;
              end
            end else begin
              // Shift in from the top so the first byte ends up in the low lane.
              word_r     <= {byte_data, word_r[LOW_W-1:8]};
              byte_idx_r <= byte_idx_r + ONE_IDX;
            end
          end else begin
            state_r <= RECV;
          end
        end
        WRITE: begin
          addr_r      <= addr_r + ONE_ADDR;
          remaining_r <= remaining_r - ONE_CNT;
          byte_idx_r  <= ZERO_IDX;
          if (remaining_r == ONE_CNT) begin
            state_r <= FINISH;
            done_r  <= 1'b1;
          end else begin
            state_r      <= RECV;
            byte_ready_r <= 1'b1;
          end
        end
        FINISH: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          byte_ready_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-accurate vector table plus
// model-driven streaming sequences for stalls, count clamping and resets.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int pass_cnt = 0;
  int total_cnt = 0;

  imem_loader #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(256)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [8:0]  wc;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [19:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] img[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic [8:0] w, input logic v,
                     input logic [7:0] d, input logic er, input logic ew, input logic [7:0] ea,
                     input logic [19:0] ed, input logic eb, input logic edn, input logic ee);
    vec_t t;
    t.rst = r; t.start = s; t.wc = w; t.valid = v; t.data = d;
    t.ready = er; t.we = ew; t.addr = ea; t.wdata = ed; t.busy = eb; t.done = edn; t.err = ee;
    vecs.push_back(t);
  endtask

  // Streams img[] into a load of wc words and checks every cycle against a
  // small model. mode 0: valid always high; mode 1: valid pattern 1,0,0,...
  // glitch_cyc > 0 pulses start with a different count in that cycle.
  task automatic stream_load(input int wc, input int mode, input int glitch_cyc,
                             input int exp_writes, input string tag);
    int cnt, ptr, pos, wr, c;
    logic ewe, edone, eerr, cur_we, cur_done, v, finished;
    logic [19:0] eword;
    logic [15:0] part;
    logic [7:0] b;
    cnt = (wc > 256) ? 256 : wc;
    ptr = 0; pos = 0; wr = 0;
    ewe = 1'b0; edone = (cnt == 0); eerr = 1'b0; finished = 1'b0;
    eword = 20'h0; part = 16'h0;
    start = 1'b1; word_count = 9'(wc); byte_valid = 1'b0; byte_data = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (c = 1; c < 4000 && !finished; c++) begin
      v = (mode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      if (ptr >= img.size()) v = 1'b0;
      byte_valid = v;
      byte_data = v ? img[ptr] : 8'h00;
      start = (c == glitch_cyc);
      word_count = (c == glitch_cyc) ? 9'd5 : 9'(wc);
      @(negedge clk);
      cur_we = ewe; cur_done = edone;
      check({tag, "_ctl"}, {byte_ready, mem_we, busy, done},
            {!cur_we && !cur_done, cur_we, 1'b1, cur_done});
      if (cur_done) begin
        check({tag, "_err"}, error, eerr);
        finished = 1'b1;
      end else if (cur_we) begin
        check({tag, "_waddr"}, mem_addr, 64'(wr));
        check({tag, "_wdata"}, mem_wdata, eword);
        wr++;
        ewe = 1'b0;
        if (wr == cnt) edone = 1'b1;
      end else if (v) begin
        b = img[ptr];
        ptr++;
        if (pos == 0) begin
          part[7:0] = b;
        end else if (pos == 1) begin
          part[15:8] = b;
        end else if (b[7:4] != 4'h0) begin
          edone = 1'b1; eerr = 1'b1;
        end else begin
          ewe = 1'b1; eword = {b[3:0], part};
        end
        pos = (pos + 1) % 3;
      end
      @(posedge clk); #1;
    end
    if (!finished) begin
      total_cnt++;
      $display("FAIL %s_timeout: got no done, expected done within 4000 cycles", tag);
    end
    byte_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {busy, done, byte_ready, mem_we}, 4'b0000);
    check({tag, "_nwrites"}, 64'(wr), 64'(exp_writes));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [19:0] w;
    rst = 1'b1; start = 1'b0; word_count = 9'd0; byte_valid = 1'b0; byte_data = 8'h00;
    @(posedge clk); #1;

    // Reset with random inputs and start held high.
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1; start = 1'b1;
      word_count = 9'($urandom_range(1, 511));
      byte_valid = 1'($urandom); byte_data = 8'($urandom);
      @(negedge clk);
      check("reset_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error}, 64'h0);
      @(posedge clk); #1;
    end

    // Cycle-by-cycle table.
    add(0, 0, 9'd0, 1, 8'hAA, 0, 0, 8'h00, 20'h00000, 0, 0, 0);
    // Basic load: two words back-to-back.
    add(0, 1, 9'd2, 0, 8'h00, 0, 0, 8'h00, 20'h00000, 0, 0, 0);
    add(0, 0, 9'd2, 1, 8'h34, 1, 0, 8'h00, 20'h00000, 1, 0, 0);
    add(0, 0, 9'd2, 1, 8'h12, 1, 0, 8'h00, 20'h00000, 1, 0, 0);
    add(0, 0, 9'd2, 1, 8'h0A, 1, 0, 8'h00, 20'h00000, 1, 0, 0);
    add(0, 0, 9'd2, 1, 8'hFF, 0, 1, 8'h00, 20'h0A1234, 1, 0, 0);
    add(0, 0, 9'd2, 1, 8'hFF, 1, 0, 8'h00, 20'h0A1234, 1, 0, 0);
    add(0, 0, 9'd2, 1, 8'hFF, 1, 0, 8'h00, 20'h0A1234, 1, 0, 0);
    add(0, 0, 9'd2, 1, 8'h0F, 1, 0, 8'h00, 20'h0A1234, 1, 0, 0);
    add(0, 0, 9'd2, 0, 8'h00, 0, 1, 8'h01, 20'hFFFFF, 1, 0, 0);
    add(0, 0, 9'd2, 0, 8'h00, 0, 0, 8'h01, 20'hFFFFF, 1, 1, 0);
    add(0, 0, 9'd2, 0, 8'h00, 0, 0, 8'h01, 20'hFFFFF, 0, 0, 0);
    // Format error on the second word.
    add(0, 1, 9'd3, 0, 8'h00, 0, 0, 8'h01, 20'hFFFFF, 0, 0, 0);
    add(0, 0, 9'd3, 1, 8'h01, 1, 0, 8'h01, 20'hFFFFF, 1, 0, 0);
    add(0, 0, 9'd3, 1, 8'h00, 1, 0, 8'h01, 20'hFFFFF, 1, 0, 0);
    add(0, 0, 9'd3, 1, 8'h00, 1, 0, 8'h01, 20'hFFFFF, 1, 0, 0);
    add(0, 0, 9'd3, 1, 8'h02, 0, 1, 8'h00, 20'h00001, 1, 0, 0);
    add(0, 0, 9'd3, 1, 8'h02, 1, 0, 8'h00, 20'h00001, 1, 0, 0);
    add(0, 0, 9'd3, 1, 8'h00, 1, 0, 8'h00, 20'h00001, 1, 0, 0);
    add(0, 0, 9'd3, 1, 8'h1A, 1, 0, 8'h00, 20'h00001, 1, 0, 0);
    add(0, 0, 9'd3, 0, 8'h00, 0, 0, 8'h00, 20'h00001, 1, 1, 1);
    add(0, 0, 9'd3, 0, 8'h00, 0, 0, 8'h00, 20'h00001, 0, 0, 1);
    // Zero-count load clears the sticky error.
    add(0, 1, 9'd0, 0, 8'h00, 0, 0, 8'h00, 20'h00001, 0, 0, 1);
    add(0, 0, 9'd0, 0, 8'h00, 0, 0, 8'h00, 20'h00001, 1, 1, 0);
    add(0, 0, 9'd0, 0, 8'h00, 0, 0, 8'h00, 20'h00001, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start = vecs[i].start; word_count = vecs[i].wc;
      byte_valid = vecs[i].valid; byte_data = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error},
            {vecs[i].ready, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].busy, vecs[i].done, vecs[i].err});
      @(posedge clk); #1;
    end

    // Reset after four bytes of a two-word load.
    seq = '{8'h34, 8'h12, 8'h0A, 8'hFF, 8'hFF};
    start = 1'b1; word_count = 9'd2; byte_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      byte_valid = 1'b1; byte_data = seq[c-1];
      @(negedge clk);
      if (c == 4) check("rst_mid_first_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h00, 20'h0A1234});
      @(posedge clk); #1;
    end
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_mid_idle", {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error}, 64'h0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;

    // Fresh single-word load from addr 0.
    img = '{8'h55, 8'h66, 8'h07};
    stream_load(1, 0, 0, 1, "fresh");

    // Backpressure on the basic image.
    img = '{8'h34, 8'h12, 8'h0A, 8'hFF, 8'hFF, 8'h0F};
    stream_load(2, 1, 0, 2, "bp");

    // start pulsed during RECV is ignored.
    stream_load(2, 0, 2, 2, "glitch");

    // Format error via the streaming model, then count clamp at 256.
    img = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h1A};
    stream_load(3, 1, 0, 1, "fmterr");

    img.delete();
    for (int k = 0; k < 300; k++) begin
      w = 20'(k * 32'h1357 + 32'd5);
      img.push_back(w[7:0]);
      img.push_back(w[15:8]);
      img.push_back({4'h0, w[19:16]});
    end
    stream_load(300, 0, 0, 256, "clamp");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
